// File: rtl/keycode_pkg.sv
// Shared types for the keycode event decoder: event record, "no key" code and FSM states.
package keycode_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef struct packed {
    logic       make;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    StIdle,
    StPushBrk,
    StPushMak
  } key_state_e;

endpackage

// File: rtl/keycode_event_decoder_if.sv
// Event pop handshake between the keycode decoder (master) and the game logic (slave).
interface keycode_event_decoder_if;

  logic       evt_valid;
  logic       evt_ready;
  logic       evt_make;
  logic [7:0] evt_code;

  modport master (
    output evt_valid,
    output evt_make,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_make,
    input  evt_code,
    output evt_ready
  );

endinterface

// File: rtl/keycode_fifo.sv
// Synchronous show-ahead FIFO of key events; head reads as zero when empty.
module keycode_fifo
  import keycode_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  key_evt_t                 wdata,
  input  logic                     pop,
  output key_evt_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  key_evt_t        mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? key_evt_t'('0) : mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// Filters the raw PIO keycode and queues make/break events for the game logic.
// Auto-repeat of held keys is built only when KEYCODE_REPEAT_EN is defined.
module keycode_event_decoder
  import keycode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH    = 8
`ifdef KEYCODE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    keycode,
  keycode_event_decoder_if.master       evt,
  output logic [7:0]                    cur_key,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned CntW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntArm = CntW'(STABLE_CYCLES - 2);

  key_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]    cand_q, cur_q, cur_d, old_q, old_d, new_q, new_d;
  logic          overflow_q, overflow_d;
  logic          accept;
  logic          fsm_push, push, pop, full, empty;
  key_evt_t      fsm_evt, push_evt, head;

  // Counter saturates so a change held during a busy FSM is still seen once it is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (keycode != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign accept = (state_q == StIdle) && (keycode == cand_q) && (cnt_q >= CntArm) &&
                  (cand_q != cur_q);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    old_d    = old_q;
    new_d    = new_q;
    fsm_push = 1'b0;
    fsm_evt  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          old_d   = cur_q;
          new_d   = cand_q;
          cur_d   = cand_q;
          state_d = (cur_q != KEY_NONE) ? StPushBrk : StPushMak;
        end
      end
      StPushBrk: begin
        fsm_push = 1'b1;
        fsm_evt  = '{make: 1'b0, code: old_q};
        state_d  = (new_q != KEY_NONE) ? StPushMak : StIdle;
      end
      StPushMak: begin
        fsm_push = 1'b1;
        fsm_evt  = '{make: 1'b1, code: new_q};
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef KEYCODE_REPEAT_EN
  logic [31:0] rpt_q, rpt_d;
  logic        first_q, first_d;
  logic        rpt_push;

  // rpt_q counts cycles since the last make (original or repeated) of the held key.
  always_comb begin
    rpt_d    = rpt_q;
    first_d  = first_q;
    rpt_push = 1'b0;
    if (state_q == StPushMak) begin
      rpt_d   = 32'd1;
      first_d = 1'b1;
    end else if (accept || (state_q != StIdle) || (cur_q == KEY_NONE)) begin
      rpt_d = '0;
    end else if (rpt_q == (first_q ? REPEAT_DELAY : REPEAT_PERIOD)) begin
      rpt_push = 1'b1;
      rpt_d    = 32'd1;
      first_d  = 1'b0;
    end else begin
      rpt_d = rpt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  assign push     = fsm_push | rpt_push;
  assign push_evt = fsm_push ? fsm_evt : key_evt_t'{make: 1'b1, code: cur_q};
`else
  assign push     = fsm_push;
  assign push_evt = fsm_evt;
`endif

  assign pop = ~empty & evt.evt_ready;

  // A drop outranks a same-cycle clear so no lost event goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cand_q     <= KEY_NONE;
      cur_q      <= KEY_NONE;
      old_q      <= KEY_NONE;
      new_q      <= KEY_NONE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= keycode;
      cur_q      <= cur_d;
      old_q      <= old_d;
      new_q      <= new_d;
      overflow_q <= overflow_d;
    end
  end

  keycode_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_evt),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign evt.evt_valid = ~empty;
  assign evt.evt_make  = head.make;
  assign evt.evt_code  = head.code;
  assign cur_key       = cur_q;
  assign overflow      = overflow_q;

endmodule
